// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage sequencer: result-select encoding, FSM states,
// issue vector bit positions.
package ex_pkg;

   typedef enum logic [2:0] {
      SelNone   = 3'd0,
      SelAddSub = 3'd1,
      SelLogic  = 3'd2,
      SelShift  = 3'd3,
      SelMul    = 3'd4,
      SelLd     = 3'd5,
      SelBr     = 3'd6
   } wb_sel_e;

   typedef enum logic [1:0] {
      StIdle,
      StMulBusy,
      StLdWait,
      StFlush
   } ex_state_e;

   localparam int unsigned NumUnits = 7;
   localparam int unsigned IssInte  = 0;
   localparam int unsigned IssLogic = 1;
   localparam int unsigned IssShift = 2;
   localparam int unsigned IssMul   = 3;
   localparam int unsigned IssLd    = 4;
   localparam int unsigned IssSt    = 5;
   localparam int unsigned IssBr    = 6;

   localparam int unsigned CntW = 8;

endpackage

// File: rtl/ex_class_prio.sv
// Priority encoder: picks one instruction class from the decode flags (br>ld>st>mul>shift>logic>inte)
// and the matching writeback result select.
module ex_class_prio
   import ex_pkg::*;
(
   input  logic                ctrl_inte_i,
   input  logic                ctrl_logic_i,
   input  logic                ctrl_shift_i,
   input  logic                ctrl_mul_i,
   input  logic                ctrl_ld_i,
   input  logic                ctrl_st_i,
   input  logic                ctrl_br_i,
   output logic [NumUnits-1:0] class_oh_o,
   output wb_sel_e             wb_sel_o
);

   always_comb begin
      class_oh_o = '0;
      wb_sel_o   = SelNone;
      if (ctrl_br_i) begin
         class_oh_o[IssBr] = 1'b1;
         wb_sel_o          = SelBr;
      end else if (ctrl_ld_i) begin
         class_oh_o[IssLd] = 1'b1;
         wb_sel_o          = SelLd;
      end else if (ctrl_st_i) begin
         // Stores produce no register result.
         class_oh_o[IssSt] = 1'b1;
      end else if (ctrl_mul_i) begin
         class_oh_o[IssMul] = 1'b1;
         wb_sel_o           = SelMul;
      end else if (ctrl_shift_i) begin
         class_oh_o[IssShift] = 1'b1;
         wb_sel_o             = SelShift;
      end else if (ctrl_logic_i) begin
         class_oh_o[IssLogic] = 1'b1;
         wb_sel_o             = SelLogic;
      end else if (ctrl_inte_i) begin
         class_oh_o[IssInte] = 1'b1;
         wb_sel_o            = SelAddSub;
      end
   end

endmodule

// File: rtl/ex_sequencer.sv
// EX-stage controller: issues one decoded instruction per cycle, sequences multiply and load
// latency, drives writeback control, upstream stall and taken-branch flush.
module ex_sequencer
   import ex_pkg::*;
#(
   parameter int unsigned MUL_LAT      = 3,
   parameter int unsigned LD_LAT       = 1,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                v_i,
   input  logic                ctrl_inte_i,
   input  logic                ctrl_logic_i,
   input  logic                ctrl_shift_i,
   input  logic                ctrl_mul_i,
   input  logic                ctrl_ld_i,
   input  logic                ctrl_st_i,
   input  logic                ctrl_br_i,
   input  logic                rsv_i,
   input  logic [3:0]          rd_addr_i,
   input  logic                branch_taken_i,
   input  logic                stall_i,
   output logic                stall_o,
   output logic [NumUnits-1:0] issue_o,
   output logic                flag_we_o,
   output logic                v_o,
   output logic                wb_en_o,
   output logic [3:0]          wb_addr_o,
   output logic [2:0]          wb_sel_o,
   output logic                flush_o
);

   ex_state_e           state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                v_q, v_d, wb_en_q, wb_en_d, flush_q, flush_d;
   logic [3:0]          wb_addr_q, wb_addr_d, lat_rd_q, lat_rd_d;
   wb_sel_e             wb_sel_q, wb_sel_d, lat_sel_q, lat_sel_d, cls_sel;
   logic                lat_rsv_q, lat_rsv_d;
   logic [NumUnits-1:0] cls_oh;
   logic                accept, writes_rd;

   ex_class_prio u_class_prio (
      .ctrl_inte_i  (ctrl_inte_i),
      .ctrl_logic_i (ctrl_logic_i),
      .ctrl_shift_i (ctrl_shift_i),
      .ctrl_mul_i   (ctrl_mul_i),
      .ctrl_ld_i    (ctrl_ld_i),
      .ctrl_st_i    (ctrl_st_i),
      .ctrl_br_i    (ctrl_br_i),
      .class_oh_o   (cls_oh),
      .wb_sel_o     (cls_sel)
   );

   assign stall_o   = (state_q == StMulBusy) || (state_q == StLdWait) || stall_i;
   assign accept    = v_i && !stall_o && (state_q != StFlush);
   assign issue_o   = accept ? cls_oh : '0;
   assign flag_we_o = accept && (cls_oh[IssInte] || cls_oh[IssLogic] || cls_oh[IssShift]);
   // NOPs, stores and branches never write the register file.
   assign writes_rd = rsv_i && (cls_oh[IssInte] || cls_oh[IssLogic] || cls_oh[IssShift] ||
                                cls_oh[IssMul] || cls_oh[IssLd]);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      v_d       = v_q;
      wb_en_d   = wb_en_q;
      wb_addr_d = wb_addr_q;
      wb_sel_d  = wb_sel_q;
      flush_d   = 1'b0;
      lat_rd_d  = lat_rd_q;
      lat_rsv_d = lat_rsv_q;
      lat_sel_d = lat_sel_q;
      if (!stall_i) begin
         v_d       = 1'b0;
         wb_en_d   = 1'b0;
         wb_addr_d = '0;
         wb_sel_d  = SelNone;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (cls_oh[IssMul] && (MUL_LAT > 1)) begin
                     state_d   = StMulBusy;
                     cnt_d     = CntW'(MUL_LAT - 1);
                     lat_rd_d  = rd_addr_i;
                     lat_rsv_d = writes_rd;
                     lat_sel_d = cls_sel;
                  end else if (cls_oh[IssLd] && (LD_LAT > 0)) begin
                     state_d   = StLdWait;
                     cnt_d     = CntW'(LD_LAT);
                     lat_rd_d  = rd_addr_i;
                     lat_rsv_d = writes_rd;
                     lat_sel_d = cls_sel;
                  end else begin
                     v_d       = 1'b1;
                     wb_en_d   = writes_rd;
                     wb_addr_d = rd_addr_i;
                     wb_sel_d  = cls_sel;
                     if (cls_oh[IssBr] && branch_taken_i) begin
                        flush_d = 1'b1;
                        state_d = StFlush;
                        cnt_d   = CntW'(FLUSH_CYCLES - 1);
                     end
                  end
               end
            end
            StMulBusy, StLdWait: begin
               // Result is produced on the cycle the counter would reach zero.
               if (cnt_q <= CntW'(1)) begin
                  state_d   = StIdle;
                  cnt_d     = '0;
                  v_d       = 1'b1;
                  wb_en_d   = lat_rsv_q;
                  wb_addr_d = lat_rd_q;
                  wb_sel_d  = lat_sel_q;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            StFlush: begin
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         v_q       <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_sel_q  <= SelNone;
         flush_q   <= 1'b0;
         lat_rd_q  <= '0;
         lat_rsv_q <= 1'b0;
         lat_sel_q <= SelNone;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         v_q       <= v_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_sel_q  <= wb_sel_d;
         flush_q   <= flush_d;
         lat_rd_q  <= lat_rd_d;
         lat_rsv_q <= lat_rsv_d;
         lat_sel_q <= lat_sel_d;
      end
   end

   assign v_o       = v_q;
   assign wb_en_o   = wb_en_q;
   assign wb_addr_o = wb_addr_q;
   assign wb_sel_o  = wb_sel_q;
   assign flush_o   = flush_q;

endmodule

// File: tb/tb_ex_sequencer.sv
// Directed bench for ex_sequencer (MUL_LAT=3, LD_LAT=1, FLUSH_CYCLES=2) with hand-computed expectations.
module tb_ex_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       v_i;
   logic [6:0] ctrl;  // {br,st,ld,mul,shift,logic,inte}
   logic       rsv_i;
   logic [3:0] rd_addr_i;
   logic       branch_taken_i;
   logic       stall_i;
   logic       stall_o;
   logic [6:0] issue_o;
   logic       flag_we_o;
   logic       v_o;
   logic       wb_en_o;
   logic [3:0] wb_addr_o;
   logic [2:0] wb_sel_o;
   logic       flush_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ex_sequencer #(
      .MUL_LAT      (3),
      .LD_LAT       (1),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .v_i            (v_i),
      .ctrl_inte_i    (ctrl[0]),
      .ctrl_logic_i   (ctrl[1]),
      .ctrl_shift_i   (ctrl[2]),
      .ctrl_mul_i     (ctrl[3]),
      .ctrl_ld_i      (ctrl[4]),
      .ctrl_st_i      (ctrl[5]),
      .ctrl_br_i      (ctrl[6]),
      .rsv_i          (rsv_i),
      .rd_addr_i      (rd_addr_i),
      .branch_taken_i (branch_taken_i),
      .stall_i        (stall_i),
      .stall_o        (stall_o),
      .issue_o        (issue_o),
      .flag_we_o      (flag_we_o),
      .v_o            (v_o),
      .wb_en_o        (wb_en_o),
      .wb_addr_o      (wb_addr_o),
      .wb_sel_o       (wb_sel_o),
      .flush_o        (flush_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] c, input logic rsv, input logic [3:0] rd,
                        input logic taken);
      v_i            = v;
      ctrl           = c;
      rsv_i          = rsv;
      rd_addr_i      = rd;
      branch_taken_i = taken;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 7'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic check_wb(input string tag, input logic v, input logic en, input logic [3:0] addr,
                           input logic [2:0] sel);
      check({tag, ".v"}, 32'(v_o), 32'(v));
      check({tag, ".en"}, 32'(wb_en_o), 32'(en));
      check({tag, ".sel"}, 32'(wb_sel_o), 32'(sel));
      if (v) check({tag, ".addr"}, 32'(wb_addr_o), 32'(addr));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".stall"}, 32'(stall_o), 32'd0);
      check({tag, ".issue"}, 32'(issue_o), 32'd0);
      check({tag, ".flag"}, 32'(flag_we_o), 32'd0);
      check({tag, ".flush"}, 32'(flush_o), 32'd0);
      check({tag, ".addr"}, 32'(wb_addr_o), 32'd0);
      check_wb(tag, 1'b0, 1'b0, 4'd0, 3'd0);
   endtask

   initial begin
      rst     = 1'b1;
      stall_i = 1'b0;
      idle();
      tick();
      tick();
      check_quiet("reset");
      rst = 1'b0;
      tick();

      // add/sub, logic, NOP, and priority among single-cycle classes
      drive(1'b1, 7'b0000001, 1'b1, 4'd5, 1'b0);
      check("inte.issue", 32'(issue_o), 32'h01);
      check("inte.flag", 32'(flag_we_o), 32'd1);
      tick();
      drive(1'b1, 7'b0000010, 1'b0, 4'd9, 1'b0);
      check_wb("inte", 1'b1, 1'b1, 4'd5, 3'd1);
      check("logic.issue", 32'(issue_o), 32'h02);
      tick();
      drive(1'b1, 7'b0000000, 1'b1, 4'd4, 1'b0);
      check_wb("logic", 1'b1, 1'b0, 4'd9, 3'd2);
      check("nop.issue", 32'(issue_o), 32'h00);
      check("nop.flag", 32'(flag_we_o), 32'd0);
      tick();
      drive(1'b1, 7'b0000111, 1'b1, 4'd1, 1'b0);
      check_wb("nop", 1'b1, 1'b0, 4'd4, 3'd0);
      check("prio.issue", 32'(issue_o), 32'h04);
      tick();
      idle();
      check_wb("prio", 1'b1, 1'b1, 4'd1, 3'd3);

      // multiply: held decode instruction accepted on the result cycle
      drive(1'b1, 7'b0001000, 1'b1, 4'd3, 1'b0);
      check("mul.issue", 32'(issue_o), 32'h08);
      check("mul.flag", 32'(flag_we_o), 32'd0);
      tick();
      drive(1'b1, 7'b0000001, 1'b1, 4'd8, 1'b0);
      check("mul.c1.stall", 32'(stall_o), 32'd1);
      check("mul.c1.issue", 32'(issue_o), 32'd0);
      check("mul.c1.v", 32'(v_o), 32'd0);
      tick();
      check("mul.c2.stall", 32'(stall_o), 32'd1);
      check("mul.c2.v", 32'(v_o), 32'd0);
      tick();
      check("mul.c3.stall", 32'(stall_o), 32'd0);
      check_wb("mul.c3", 1'b1, 1'b1, 4'd3, 3'd4);
      check("mul.held.issue", 32'(issue_o), 32'h01);
      tick();
      idle();
      check_wb("mul.held", 1'b1, 1'b1, 4'd8, 3'd1);

      // taken branch: two dropped instructions, third accepted
      drive(1'b1, 7'b1000000, 1'b1, 4'd2, 1'b1);
      check("br.issue", 32'(issue_o), 32'h40);
      tick();
      drive(1'b1, 7'b0000001, 1'b1, 4'd11, 1'b0);
      check("br.c1.flush", 32'(flush_o), 32'd1);
      check("br.c1.stall", 32'(stall_o), 32'd0);
      check("br.c1.issue", 32'(issue_o), 32'd0);
      check_wb("br.c1", 1'b1, 1'b0, 4'd2, 3'd6);
      tick();
      drive(1'b1, 7'b0000001, 1'b1, 4'd12, 1'b0);
      check("br.c2.flush", 32'(flush_o), 32'd0);
      check("br.c2.issue", 32'(issue_o), 32'd0);
      check("br.c2.v", 32'(v_o), 32'd0);
      tick();
      drive(1'b1, 7'b0000001, 1'b1, 4'd13, 1'b0);
      check("br.c3.v", 32'(v_o), 32'd0);
      check("br.c3.issue", 32'(issue_o), 32'h01);
      tick();
      idle();
      check_wb("br.c4", 1'b1, 1'b1, 4'd13, 3'd1);

      // not-taken branch: no flush, next instruction accepted at once
      drive(1'b1, 7'b1000000, 1'b1, 4'd2, 1'b0);
      tick();
      drive(1'b1, 7'b0000010, 1'b1, 4'd6, 1'b0);
      check("brnt.flush", 32'(flush_o), 32'd0);
      check_wb("brnt", 1'b1, 1'b0, 4'd2, 3'd6);
      check("brnt.next.issue", 32'(issue_o), 32'h02);
      tick();
      idle();
      check_wb("brnt.next", 1'b1, 1'b1, 4'd6, 3'd2);

      // load wins over store
      drive(1'b1, 7'b0110000, 1'b1, 4'd7, 1'b0);
      check("ld.issue", 32'(issue_o), 32'h10);
      tick();
      idle();
      check("ld.c1.stall", 32'(stall_o), 32'd1);
      check("ld.c1.v", 32'(v_o), 32'd0);
      tick();
      check("ld.c2.stall", 32'(stall_o), 32'd0);
      check_wb("ld.c2", 1'b1, 1'b1, 4'd7, 3'd5);

      // store alone
      drive(1'b1, 7'b0100000, 1'b1, 4'd4, 1'b0);
      check("st.issue", 32'(issue_o), 32'h20);
      tick();
      idle();
      check_wb("st", 1'b1, 1'b0, 4'd4, 3'd0);

      // downstream stall during MUL_BUSY cnt=1 delays the result by exactly two cycles
      drive(1'b1, 7'b0001000, 1'b1, 4'd6, 1'b0);
      tick();
      idle();
      tick();
      stall_i = 1'b1;
      #1;
      check("mst.c2.stall", 32'(stall_o), 32'd1);
      tick();
      check("mst.c3.v", 32'(v_o), 32'd0);
      tick();
      check("mst.c4.v", 32'(v_o), 32'd0);
      stall_i = 1'b0;
      #1;
      check("mst.c4.stall", 32'(stall_o), 32'd1);
      tick();
      check_wb("mst.c5", 1'b1, 1'b1, 4'd6, 3'd4);
      stall_i = 1'b1;
      tick();
      check_wb("mst.hold", 1'b1, 1'b1, 4'd6, 3'd4);
      stall_i = 1'b0;
      tick();
      check("mst.after.v", 32'(v_o), 32'd0);

      // flush pulse is not repeated while stalled
      drive(1'b1, 7'b1000000, 1'b0, 4'd0, 1'b1);
      tick();
      idle();
      stall_i = 1'b1;
      #1;
      check("bst.c1.flush", 32'(flush_o), 32'd1);
      tick();
      check("bst.c2.flush", 32'(flush_o), 32'd0);
      stall_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // reset during MUL_BUSY cnt=1 aborts the multiply
      drive(1'b1, 7'b0001000, 1'b1, 4'd9, 1'b0);
      tick();
      idle();
      tick();
      rst = 1'b1;
      tick();
      check_quiet("mrst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mrst.nov", 32'(v_o), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach summary, got running expected finished");
      $fatal(1);
   end

endmodule
